// File: rtl/stage_wb_if.sv
// stage_wb_if: EX-stage inputs, decode read addresses and writeback outputs of stage_wb.
// The EX/decode side drives through master; stage_wb connects through slave.
interface stage_wb_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] mem_rdata_in;
  logic [DATA_W-1:0] link_in;
  logic [3:0]        reg_wa_in;
  logic              reg_we_in;
  logic              should_bypass_data_in;
  logic              bl_in;
  logic              branch_taken_in;
  logic              cond_pass_in;
  logic              is_invalid_in;
  logic [3:0]        rn_a_in;
  logic [3:0]        rm_a_in;
  logic              rn_re_in;
  logic              rm_re_in;
  logic              reg_we_final_out;
  logic [DATA_W-1:0] reg_wd_out;
  logic [3:0]        reg_wa_out;
  logic              stall_out;
  logic              make_invalid_out;
  logic [31:0]       retired_count_out;

  modport master (
    output alu_result_in, mem_rdata_in, link_in, reg_wa_in, reg_we_in,
           should_bypass_data_in, bl_in, branch_taken_in, cond_pass_in,
           is_invalid_in, rn_a_in, rm_a_in, rn_re_in, rm_re_in,
    input  reg_we_final_out, reg_wd_out, reg_wa_out, stall_out,
           make_invalid_out, retired_count_out
  );

  modport slave (
    input  alu_result_in, mem_rdata_in, link_in, reg_wa_in, reg_we_in,
           should_bypass_data_in, bl_in, branch_taken_in, cond_pass_in,
           is_invalid_in, rn_a_in, rm_a_in, rn_re_in, rm_re_in,
    output reg_we_final_out, reg_wd_out, reg_wa_out, stall_out,
           make_invalid_out, retired_count_out
  );
endinterface

// File: rtl/stage_wb.sv
// stage_wb: writeback stage -- register-file write port, RAW pending scoreboard,
// squash window after taken branches / PC writes, and the retired-instruction counter.
module stage_wb #(
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       reset,
  stage_wb_if.slave bus
);
  localparam logic [1:0] FLUSH_CYCLES = 2'd2;
  localparam logic [3:0] PC_REG       = 4'd15;

  logic              commit;
  logic              ex_we;
  logic              flush_load;
  logic              squash;
  logic              hit_rn;
  logic              hit_rm;
  logic              vld_p1;
  logic [3:0]        wa_p1;
  logic              bypass_p1;
  logic              bl_p1;
  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] link_p1;
  logic [15:0]       pending_q;
  logic [15:0]       pending_d;
  logic [1:0]        flush_q;
  logic [1:0]        flush_d;
  logic [31:0]       retired_q;

  assign commit     = ~bus.is_invalid_in & bus.cond_pass_in;
  assign ex_we      = bus.reg_we_in & commit;
  assign flush_load = commit & (bus.branch_taken_in |
                                (bus.reg_we_in & (bus.reg_wa_in == PC_REG)));

  // EX -> WB boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      wa_p1     <= '0;
      bypass_p1 <= 1'b0;
      bl_p1     <= 1'b0;
      alu_p1    <= '0;
      link_p1   <= '0;
    end else begin
      vld_p1    <= ex_we;
      wa_p1     <= bus.reg_wa_in;
      bypass_p1 <= bus.should_bypass_data_in;
      bl_p1     <= bus.bl_in;
      alu_p1    <= bus.alu_result_in;
      link_p1   <= bus.link_in;
    end
  end

  // A retiring write and a new write to the same register leave the bit set.
  always_comb begin
    pending_d = pending_q;
    if (vld_p1) pending_d[wa_p1] = 1'b0;
    if (ex_we)  pending_d[bus.reg_wa_in] = 1'b1;
  end

  always_comb begin
    flush_d = flush_q;
    if (flush_load)             flush_d = FLUSH_CYCLES;
    else if (flush_q != 2'd0)   flush_d = flush_q - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      flush_q   <= '0;
      retired_q <= '0;
    end else begin
      pending_q <= pending_d;
      flush_q   <= flush_d;
      if (commit) retired_q <= retired_q + 32'd1;
    end
  end

  assign hit_rn = bus.rn_re_in & (pending_q[bus.rn_a_in] |
                                  (ex_we & (bus.rn_a_in == bus.reg_wa_in)));
  assign hit_rm = bus.rm_re_in & (pending_q[bus.rm_a_in] |
                                  (ex_we & (bus.rm_a_in == bus.reg_wa_in)));

  // Squash covers the trigger cycle itself; a squashed instruction never stalls.
  assign squash = ~reset & ((flush_q != 2'd0) | flush_load);

  assign bus.make_invalid_out  = squash;
  assign bus.stall_out         = ~reset & ~squash & (hit_rn | hit_rm);
  assign bus.reg_we_final_out  = vld_p1;
  assign bus.reg_wa_out        = wa_p1;
  assign bus.reg_wd_out        = bl_p1     ? link_p1 :
                                 bypass_p1 ? alu_p1  : bus.mem_rdata_in;
  assign bus.retired_count_out = retired_q;
endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: table-driven check of stage_wb with a scoreboard queue for the
// one-cycle writeback results, plus hand-written hazard, squash, wrap and reset sequences.
module tb_stage_wb;
  typedef struct {
    logic        we, byp, bl, br, cond, inv;
    logic [3:0]  wa;
    logic [31:0] alu, link, mem;
    logic        rn_re;
    logic [3:0]  rn_a;
    logic        rm_re;
    logic [3:0]  rm_a;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_stall, exp_sq;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [31:0] mem;
  } exp_t;

  logic        clk;
  logic        reset;
  int          checks;
  int          errors;
  logic [31:0] exp_ret;
  exp_t        sbq[$];
  vec_t        tbl[8];
  exp_t        cleared;

  stage_wb_if #(.DATA_W(32)) bus();
  stage_wb #(.DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t op(logic we, logic byp, logic bl, logic br, logic cond, logic inv,
                              logic [3:0] wa, logic [31:0] alu, logic [31:0] link,
                              logic [31:0] mem, logic rn_re, logic [3:0] rn_a,
                              logic rm_re, logic [3:0] rm_a, logic exp_we,
                              logic [31:0] exp_wd, logic exp_stall, logic exp_sq);
    vec_t v;
    v.we = we; v.byp = byp; v.bl = bl; v.br = br; v.cond = cond; v.inv = inv;
    v.wa = wa; v.alu = alu; v.link = link; v.mem = mem;
    v.rn_re = rn_re; v.rn_a = rn_a; v.rm_re = rm_re; v.rm_a = rm_a;
    v.exp_we = exp_we; v.exp_wd = exp_wd; v.exp_stall = exp_stall; v.exp_sq = exp_sq;
    return v;
  endfunction

  function automatic vec_t bub(logic rn_re, logic [3:0] rn_a, logic rm_re, logic [3:0] rm_a,
                               logic exp_stall, logic exp_sq);
    return op(0, 0, 0, 0, 0, 1, 4'd0, 32'd0, 32'd0, 32'd0, rn_re, rn_a, rm_re, rm_a,
              0, 32'd0, exp_stall, exp_sq);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.reg_we_in             = v.we;
    bus.should_bypass_data_in = v.byp;
    bus.bl_in                 = v.bl;
    bus.branch_taken_in       = v.br;
    bus.cond_pass_in          = v.cond;
    bus.is_invalid_in         = v.inv;
    bus.reg_wa_in             = v.wa;
    bus.alu_result_in         = v.alu;
    bus.link_in               = v.link;
    bus.rn_re_in              = v.rn_re;
    bus.rn_a_in               = v.rn_a;
    bus.rm_re_in              = v.rm_re;
    bus.rm_a_in               = v.rm_a;
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s.sb: got empty expected entry", tag);
      e = cleared;
    end else begin
      e = sbq.pop_front();
    end
    bus.mem_rdata_in = e.mem;
    apply(v);
    #1;
    chk({tag, ".we"},      {31'd0, bus.reg_we_final_out}, {31'd0, e.we});
    chk({tag, ".wa"},      {28'd0, bus.reg_wa_out},       {28'd0, e.wa});
    chk({tag, ".wd"},      bus.reg_wd_out,                e.wd);
    chk({tag, ".stall"},   {31'd0, bus.stall_out},        {31'd0, v.exp_stall});
    chk({tag, ".squash"},  {31'd0, bus.make_invalid_out}, {31'd0, v.exp_sq});
    chk({tag, ".retired"}, bus.retired_count_out,         exp_ret);
    sbq.push_back('{we: v.exp_we, wa: v.wa, wd: v.exp_wd, mem: v.mem});
    if (v.cond && !v.inv) exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_ret = '0;
    cleared = '{we: 1'b0, wa: 4'd0, wd: 32'd0, mem: 32'd0};

    //        we byp bl br cd iv wa  alu           link      mem           rn      rm      ewe ewd          stl sq
    tbl[0] = op(1, 1, 0, 0, 1, 0, 3, 32'h1234,     32'h0,    32'h0,        0, 0,   0, 0,   1, 32'h1234,     0, 0);
    tbl[1] = op(1, 0, 0, 0, 1, 0, 5, 32'h5000,     32'h0,    32'hCAFEF00D, 0, 0,   0, 0,   1, 32'hCAFEF00D, 0, 0);
    tbl[2] = op(1, 1, 0, 0, 0, 0, 7, 32'hDEAD,     32'h0,    32'h0,        0, 0,   0, 0,   0, 32'hDEAD,     0, 0);
    tbl[3] = op(1, 1, 0, 0, 1, 1, 9, 32'h55,       32'h0,    32'h0,        0, 0,   0, 0,   0, 32'h55,       0, 0);
    tbl[4] = op(1, 1, 1, 0, 1, 0, 14, 32'h999,     32'h104,  32'h777,      0, 0,   0, 0,   1, 32'h104,      0, 0);
    tbl[5] = op(0, 1, 0, 0, 1, 0, 1, 32'hA5A5A5A5, 32'h0,    32'h0,        0, 0,   0, 0,   0, 32'hA5A5A5A5, 0, 0);
    tbl[6] = op(1, 0, 0, 0, 1, 0, 0, 32'h10,       32'h0,    32'hFFFFFFFF, 0, 0,   0, 0,   1, 32'hFFFFFFFF, 0, 0);
    tbl[7] = op(1, 1, 0, 0, 1, 0, 12, 32'hFFFFFFFF, 32'h8,   32'h0,        0, 0,   0, 0,   1, 32'hFFFFFFFF, 0, 0);

    // Reset with a live trigger and an EX hit on the inputs: everything held low.
    reset = 1'b1;
    bus.mem_rdata_in = 32'd0;
    apply(op(1, 1, 0, 1, 1, 0, 15, 32'h1, 32'h0, 32'h0, 1, 15, 1, 15, 0, 32'h0, 0, 0));
    repeat (2) @(posedge clk);
    #2;
    chk("rst.we",      {31'd0, bus.reg_we_final_out}, 32'd0);
    chk("rst.stall",   {31'd0, bus.stall_out},        32'd0);
    chk("rst.squash",  {31'd0, bus.make_invalid_out}, 32'd0);
    chk("rst.retired", bus.retired_count_out,         32'd0);
    @(negedge clk);
    apply(bub(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    sbq.push_back(cleared);

    for (int i = 0; i < 8; i++) step(tbl[i], $sformatf("tbl%0d", i));
    step(bub(0, 0, 0, 0, 0, 0), "tbl.drain");

    // Load RAW hazard on rn, ALU hazard on rm, unused read ports.
    step(op(1, 0, 0, 0, 1, 0, 5, 32'h40, 32'h0, 32'hCAFEF00D, 1, 5, 0, 0, 1, 32'hCAFEF00D, 1, 0), "ld.ex");
    step(bub(1, 5, 0, 0, 1, 0), "ld.wb");
    step(bub(1, 5, 0, 0, 0, 0), "ld.after");
    step(op(1, 1, 0, 0, 1, 0, 8, 32'h77, 32'h0, 32'h0, 0, 0, 1, 8, 1, 32'h77, 1, 0), "rm.ex");
    step(bub(0, 0, 1, 8, 1, 0), "rm.wb");
    step(bub(0, 0, 1, 8, 0, 0), "rm.after");
    step(op(1, 1, 0, 0, 1, 0, 6, 32'h66, 32'h0, 32'h0, 0, 6, 1, 4, 1, 32'h66, 0, 0), "nore.ex");
    step(bub(0, 6, 0, 6, 0, 0), "nore.wb");

    // Condition fail and invalid: no write, no pending bit, no hazard.
    step(op(1, 1, 0, 0, 0, 0, 7, 32'h70, 32'h0, 32'h0, 1, 7, 0, 0, 0, 32'h70, 0, 0), "cf.ex");
    step(bub(1, 7, 0, 0, 0, 0), "cf.wb");
    step(op(1, 1, 0, 0, 1, 1, 7, 32'h71, 32'h0, 32'h0, 1, 7, 0, 0, 0, 32'h71, 0, 0), "inv.ex");
    step(bub(1, 7, 0, 0, 0, 0), "inv.wb");

    // Back-to-back writes to r2: pending stays set until the second one retires.
    step(op(1, 1, 0, 0, 1, 0, 2, 32'h21, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h21, 0, 0), "b2b.w1");
    step(op(1, 1, 0, 0, 1, 0, 2, 32'h22, 32'h0, 32'h0, 1, 2, 0, 0, 1, 32'h22, 1, 0), "b2b.w2");
    step(bub(1, 2, 0, 0, 1, 0), "b2b.wb2");
    step(bub(1, 2, 0, 0, 0, 0), "b2b.after");

    // BL taken to r14: three-cycle squash, squashed hazard does not stall.
    step(op(1, 0, 1, 1, 1, 0, 14, 32'h200, 32'h104, 32'h0, 1, 14, 0, 0, 1, 32'h104, 0, 1), "bl.trig");
    step(bub(1, 14, 0, 0, 0, 1), "bl.c1");
    step(bub(0, 0, 0, 0, 0, 1), "bl.c2");
    step(bub(0, 0, 0, 0, 0, 0), "bl.c3");

    // Retrigger while the counter is 1 extends the window.
    step(op(0, 1, 0, 1, 1, 0, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h300, 0, 1), "rt.trig1");
    step(bub(0, 0, 0, 0, 0, 1), "rt.c1");
    step(op(0, 1, 0, 1, 1, 0, 0, 32'h304, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h304, 0, 1), "rt.trig2");
    step(bub(0, 0, 0, 0, 0, 1), "rt.c3");
    step(bub(0, 0, 0, 0, 0, 1), "rt.c4");
    step(bub(0, 0, 0, 0, 0, 0), "rt.c5");
    step(op(0, 1, 0, 1, 0, 0, 0, 32'h308, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h308, 0, 0), "nc.br");
    step(bub(0, 0, 0, 0, 0, 0), "nc.after");

    // Write to r15 behaves like a taken branch.
    step(op(1, 1, 0, 0, 1, 0, 15, 32'h400, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h400, 0, 1), "pc.trig");
    step(bub(0, 0, 0, 0, 0, 1), "pc.c1");
    step(bub(0, 0, 0, 0, 0, 1), "pc.c2");
    step(bub(0, 0, 0, 0, 0, 0), "pc.c3");

    // Retired counter wrap.
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFFFFFF;
    step(op(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0), "wrap.commit");
    step(bub(0, 0, 0, 0, 0, 0), "wrap.after");

    // Reset in the middle of a squash window with a write in WB.
    step(op(1, 1, 0, 1, 1, 0, 4, 32'hABC, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'hABC, 0, 1), "rmid.trig");
    @(posedge clk);
    #1;
    apply(op(1, 1, 0, 1, 1, 0, 4, 32'hABD, 32'h0, 32'h0, 1, 4, 0, 0, 0, 32'h0, 0, 0));
    chk("rmid.pre_we", {31'd0, bus.reg_we_final_out}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rmid.we",      {31'd0, bus.reg_we_final_out}, 32'd0);
    chk("rmid.squash",  {31'd0, bus.make_invalid_out}, 32'd0);
    chk("rmid.stall",   {31'd0, bus.stall_out},        32'd0);
    chk("rmid.retired", bus.retired_count_out,         32'd0);
    @(negedge clk);
    apply(bub(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    sbq.delete();
    sbq.push_back(cleared);
    exp_ret = '0;
    step(bub(1, 4, 0, 0, 0, 0), "post.c1");
    step(op(1, 1, 0, 0, 1, 0, 3, 32'h33, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h33, 0, 0), "post.w");
    step(bub(0, 0, 0, 0, 0, 0), "post.wb");
    step(bub(0, 0, 0, 0, 0, 0), "post.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
